rw_step_sampler: RTL
====================

Name: rw_step_sampler

Overview:
Consumes the free-running 32-bit LFSR word and turns one walker-step request into a step decision for the random-walk engine. Each request carries a node's edge-list offset and degree. The block decides restart (teleport) versus move, and for a move computes the CSR edge address of a uniformly chosen neighbour as offset + (rand mod degree). It sits between the LFSR and the edge-fetch/memory stage, with valid/ready handshakes on both sides.

Parameters:
- DEG_W, 16, width of node degree.
- EDGE_AW, 20, width of edge-list address.
- ID_W, 8, width of walker tag.
- ALPHA_Q16, 16'h2666, restart probability in Q0.16 (16'h2666 ≈ 0.15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rand_in  in  32  LFSR output; sampled, never stalled
- req_valid  in  1  step request valid
- req_ready  out  1  block can accept a request
- req_offset  in  EDGE_AW  first edge address of current node
- req_degree  in  DEG_W  out-degree of current node
- req_id  in  ID_W  walker tag
- resp_valid  out  1  result valid
- resp_ready  in  1  downstream accepts result
- resp_restart  out  1  1 = teleport to source, 0 = move
- resp_dangling  out  1  1 = restart forced by degree 0
- resp_edge_addr  out  EDGE_AW  edge address to fetch; 0 when resp_restart = 1
- resp_id  out  ID_W  walker tag, echoed from request

Behaviour:
- Clock and reset: clk; reset is reset, synchronous, active-high.
- Reset state:
  - FSM in IDLE, req_ready = 1.
  - resp_valid, resp_restart, resp_dangling, resp_edge_addr and resp_id all 0.
  - Internal dividend, remainder and count cleared.
- Reset mid-operation (any state) aborts the transaction silently; no response is produced.
- FSM states: IDLE, SAMPLE, DIV, OUT.
- req_ready = (state == IDLE), combinational from the state register. Exactly one request is in flight.
- IDLE: on an edge where req_valid & req_ready (call it edge T):
  - Latch offset, degree and id.
  - R0 = rand_in. Restart flag = (R0[31:16] < ALPHA_Q16).
  - Go to SAMPLE.
- SAMPLE (edge T+1):
  - If degree == 0: restart = 1, dangling = 1, go to OUT.
  - Else if restart flag is set: go to OUT (dangling = 0).
  - Else: dividend = rand_in (R1, a fresh sample one cycle after R0), remainder = 0, count = 0, go to DIV.
- DIV: one restoring-remainder step per edge:
  - rem' = {rem, dividend[31]}; if rem' >= degree then rem' = rem' − degree.
  - dividend <<= 1.
  - Remainder register is DEG_W+1 bits wide.
  - After the 32nd step (count == 31), go to OUT.
  - Final remainder = R1 mod degree, always < degree.
- Entering OUT:
  - resp_edge_addr = (offset + remainder) mod 2^EDGE_AW; wraps, no overflow flag.
  - On restart, resp_edge_addr = 0.
  - resp_valid = 1.
- Latency from accept edge T to first cycle with resp_valid high:
  - Restart or dangling: resp_valid high after edge T+1.
  - Move: resp_valid high after edge T+33.
- OUT:
  - Hold all resp_* outputs stable while resp_valid & !resp_ready.
  - On resp_valid & resp_ready, drop resp_valid and go to IDLE.
  - Next accept is possible at the following edge at the earliest, so there is no same-cycle response/accept overlap.
- req_* inputs are ignored outside IDLE; no input changes affect an in-flight computation.
- Edge cases:
  - ALPHA_Q16 = 0 never restarts except when degree is 0.
  - degree = 1 always yields remainder 0.

Test Plan:
- Reset, then hold: reset high 3 cycles → req_ready = 1, resp_valid = 0, all resp_* = 0.
- Move path: ALPHA_Q16 = 16'h2666, R0 = 32'hFFFF_0000, R1 = 32'd100, degree 7, offset 1000, id 5 → resp_valid after edge T+33; resp_restart = 0, resp_edge_addr = 1002, resp_id = 5.
- Restart path: R0 = 32'h1000_0000, degree 7 → resp_valid after edge T+1; resp_restart = 1, resp_dangling = 0, resp_edge_addr = 0. Also degree 0 with R0 = 32'hFFFF_0000 → resp_restart = 1, resp_dangling = 1.
- Modulo boundaries (R0 = 32'hFFFF_0000):
  - R1 = 32'hFFFF_FFFF, degree 10 → remainder 5.
  - Same R1, degree 65535 → remainder 0.
  - Degree 1 → remainder 0.
- Address wrap: offset 20'hFFFFE, R1 = 32'hFFFF_FFFF, degree 10 → resp_edge_addr = 20'h00003.
- Backpressure and abort:
  - Hold resp_ready low 10 cycles → outputs stable and req_ready = 0 throughout; then resp_ready high → IDLE on the next edge.
  - Assert reset during DIV (cycle T+15) → no response ever appears, req_ready = 1 after reset.

Source files
------------

// File: rtl/rw_step_sampler.sv
// Random-walk step sampler: turns one walker-step request plus LFSR words into a
// restart/move decision and, for a move, the CSR edge address offset + (R1 mod degree).
module rw_step_sampler #(
    parameter int          DEG_W     = 16,
    parameter int          EDGE_AW   = 20,
    parameter int          ID_W      = 8,
    parameter logic [15:0] ALPHA_Q16 = 16'h2666
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        rand_in,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [EDGE_AW-1:0] req_offset,
    input  logic [DEG_W-1:0]   req_degree,
    input  logic [ID_W-1:0]    req_id,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_restart,
    output logic               resp_dangling,
    output logic [EDGE_AW-1:0] resp_edge_addr,
    output logic [ID_W-1:0]    resp_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        DIV    = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Request context, captured on accept and held for the whole transaction
    logic [EDGE_AW-1:0] r_offset;
    logic [DEG_W-1:0]   r_degree;
    logic [ID_W-1:0]    r_id;
    logic               r_restart;

    // Restoring-remainder divider state
    logic [31:0]        r_dividend;
    logic [DEG_W:0]     r_rem;
    logic [4:0]         r_count;

    // Registered response
    logic               r_resp_valid;
    logic               r_resp_restart;
    logic               r_resp_dangling;
    logic [EDGE_AW-1:0] r_resp_edge_addr;
    logic [ID_W-1:0]    r_resp_id;

    logic [DEG_W:0]     w_rem_shift;
    logic [DEG_W:0]     w_rem_step;
    logic [EDGE_AW-1:0] w_move_addr;
    logic               w_degree_zero;

    assign req_ready      = (r_state == IDLE);
    assign resp_valid     = r_resp_valid;
    assign resp_restart   = r_resp_restart;
    assign resp_dangling  = r_resp_dangling;
    assign resp_edge_addr = r_resp_edge_addr;
    assign resp_id        = r_resp_id;

    assign w_degree_zero = (r_degree == '0);

    // The remainder is always below degree, so its top bit is free for the shift-in
    assign w_rem_shift = {r_rem[DEG_W-1:0], r_dividend[31]};
    assign w_rem_step  = (w_rem_shift >= {1'b0, r_degree}) ?
                         (w_rem_shift - {1'b0, r_degree}) : w_rem_shift;
    assign w_move_addr = r_offset + EDGE_AW'(w_rem_step);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (w_degree_zero || r_restart) begin
                    w_state_next = OUT;
                end else begin
                    w_state_next = DIV;
                end
            end
            DIV: begin
                if (r_count == 5'd31) begin
                    w_state_next = OUT;
                end
            end
            OUT: begin
                if (resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_offset         <= '0;
            r_degree         <= '0;
            r_id             <= '0;
            r_restart        <= 1'b0;
            r_dividend       <= '0;
            r_rem            <= '0;
            r_count          <= '0;
            r_resp_valid     <= 1'b0;
            r_resp_restart   <= 1'b0;
            r_resp_dangling  <= 1'b0;
            r_resp_edge_addr <= '0;
            r_resp_id        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_offset  <= req_offset;
                        r_degree  <= req_degree;
                        r_id      <= req_id;
                        r_restart <= (rand_in[31:16] < ALPHA_Q16);
                    end
                end
                SAMPLE: begin
                    if (w_degree_zero || r_restart) begin
                        // Dangling nodes have no edge to pick, so they must teleport
                        r_resp_valid     <= 1'b1;
                        r_resp_restart   <= 1'b1;
                        r_resp_dangling  <= w_degree_zero;
                        r_resp_edge_addr <= '0;
                        r_resp_id        <= r_id;
                    end else begin
                        // R1 is a fresh word, independent of the one used for the restart draw
                        r_dividend <= rand_in;
                        r_rem      <= '0;
                        r_count    <= '0;
                    end
                end
                DIV: begin
                    r_rem      <= w_rem_step;
                    r_dividend <= {r_dividend[30:0], 1'b0};
                    r_count    <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_resp_valid     <= 1'b1;
                        r_resp_restart   <= 1'b0;
                        r_resp_dangling  <= 1'b0;
                        r_resp_edge_addr <= w_move_addr;
                        r_resp_id        <= r_id;
                    end
                end
                OUT: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
